pc_fetch_unit: RTL

- IF-stage consumer of the next-PC target: holds the fetch PC and drives the instruction-memory address.
- Captures the fetched instruction into the IF/ID pipeline register.
- Absorbs redirects (branch, j/jal, jr targets resolved in D) under hazard stalls, so a redirect raised during a stall is never lost.
- Delayed-branch MIPS: the delay-slot instruction is never squashed by a redirect.

---
 rtl/pc_fetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF stage. Holds the fetch PC, drives the IM address and
// captures the fetched instruction into the IF/ID register. A redirect
// raised while the pipe is stalled is parked in pend_target and replayed
// on the first unstalled edge, so it is never dropped. Delayed-branch
// machine: the instruction fetched in the redirect cycle (delay slot)
// always enters IF/ID.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   stall               freeze PC and IF/ID
//   redirect_valid      one-cycle pulse, take redirect_target
//   redirect_target     resolved branch / j / jal / jr target
//   clear_d             load a bubble into IF/ID (wins over stall)
//   instr_f             IM read data for pc_f
//   pc_f                fetch address
//   instr_d, pc_d       IF/ID instruction and PC
//   pc8_d               pc_d + 8 link value
//   valid_d             IF/ID holds a real instruction
//   pend_o              a stalled redirect is waiting
//   misalign_err        sticky, a target with [1:0] != 0 was accepted
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        clear_d,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        pend_o,
  output logic        misalign_err
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t      state_q,       state_d;
  logic [31:0] pc_f_q,        pc_f_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] instr_d_q,     instr_d_d;
  logic [31:0] pc_d_q,        pc_d_d;
  logic        valid_d_q,     valid_d_d;
  logic        err_q,         err_d;

  logic [31:0] tgt_aligned;
  logic        tgt_misaligned;

  // Word-align every accepted target; the error flag records that it happened.
  assign tgt_aligned    = {redirect_target[31:2], 2'b00};
  assign tgt_misaligned = |redirect_target[1:0];

  // Next-PC and redirect bookkeeping
  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    pend_target_d = pend_target_q;
    err_d         = err_q;
    if (redirect_valid && tgt_misaligned)
      err_d = 1'b1;
    if (stall) begin
      // Newest redirect seen during the stall wins.
      if (redirect_valid) begin
        pend_target_d = tgt_aligned;
        state_d       = PEND;
      end
    end else begin
      if (redirect_valid) begin
        // Live redirect beats the parked one; drop the parked target.
        pc_f_d        = tgt_aligned;
        pend_target_d = 32'h0;
        state_d       = RUN;
      end else if (state_q == PEND) begin
        pc_f_d  = pend_target_q;
        state_d = RUN;
      end else begin
        pc_f_d = pc_f_q + 32'd4;
      end
    end
  end

  // IF/ID register: clear_d overrides stall here only
  always_comb begin
    instr_d_d = instr_d_q;
    pc_d_d    = pc_d_q;
    valid_d_d = valid_d_q;
    if (clear_d) begin
      instr_d_d = NOP_WORD;
      pc_d_d    = pc_f_q;
      valid_d_d = 1'b0;
    end else if (!stall) begin
      instr_d_d = instr_f;
      pc_d_d    = pc_f_q;
      valid_d_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      pc_f_q        <= RESET_PC;
      pend_target_q <= 32'h0;
      instr_d_q     <= NOP_WORD;
      pc_d_q        <= 32'h0;
      valid_d_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      pend_target_q <= pend_target_d;
      instr_d_q     <= instr_d_d;
      pc_d_q        <= pc_d_d;
      valid_d_q     <= valid_d_d;
      err_q         <= err_d;
    end
  end

  assign pc_f         = pc_f_q;
  assign instr_d      = instr_d_q;
  assign pc_d         = pc_d_q;
  assign pc8_d        = pc_d_q + 32'd8;
  assign valid_d      = valid_d_q;
  assign pend_o       = (state_q == PEND);
  assign misalign_err = err_q;

endmodule
